program_loader: RTL and testbench

Drives the SAP-1 program-mode interface (program mode, program address, program data, program write) from a byte stream. It is the producer on the far side of the RAM programming port.
- Receives a framed byte stream on a valid/ready handshake.
- Writes each data byte into consecutive RAM addresses with setup/strobe/hold timing.
- Verifies a checksum, then holds the CPU in reset for a fixed window before releasing it to execute.

---
 rtl/program_loader_pkg.sv | 22 ++
 rtl/program_loader.sv | 158 +++++++++++++++
 tb/tb_program_loader.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - state encodings and frame limits for the SAP-1 program loader
package program_loader_pkg;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_COUNT     = 4'd1;
    localparam logic [3:0] ST_DATA      = 4'd2;
    localparam logic [3:0] ST_SETUP     = 4'd3;
    localparam logic [3:0] ST_WRITE     = 4'd4;
    localparam logic [3:0] ST_HOLD      = 4'd5;
    localparam logic [3:0] ST_CHECK     = 4'd6;
    localparam logic [3:0] ST_RESET_CPU = 4'd7;
    localparam logic [3:0] ST_DONE      = 4'd8;
    localparam logic [3:0] ST_ERROR     = 4'd9;

    localparam int MIN_COUNT = 1;
    localparam int MAX_COUNT = 16;

    function automatic logic count_is_legal(input int count, input int max_count);
        return (count >= MIN_COUNT) && (count <= max_count);
    endfunction

endpackage

// File: rtl/program_loader.sv
// rtl/program_loader.sv - loads a framed byte stream into SAP-1 RAM through its program-mode port
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int RESET_CYCLES = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_debug,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_byte,
    input  logic                  i_byte_valid,
    output logic                  o_byte_ready,
    output logic                  o_program_mode,
    output logic [ADDR_WIDTH-1:0] o_program_address,
    output logic [DATA_WIDTH-1:0] o_program_data,
    output logic                  o_program_write,
    output logic                  o_cpu_reset,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);

    localparam int LP_RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    logic [3:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_last_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_sum;
    logic [LP_RC_W-1:0]    r_rc;
    logic                  r_write;
    logic                  r_mode;
    logic                  r_cpu_reset;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;

    logic w_ready;
    logic w_transfer;
    logic w_count_ok;
    logic w_unused_debug;

    // Write tracing is a simulation concern; the pin is kept for interface compatibility.
    assign w_unused_debug = i_debug;

    assign w_ready    = (r_state == ST_COUNT) || (r_state == ST_DATA) || (r_state == ST_CHECK);
    assign w_transfer = w_ready && i_byte_valid;
    assign w_count_ok = count_is_legal(int'(i_byte), 2 ** ADDR_WIDTH);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_last_addr <= '0;
            r_data      <= '0;
            r_sum       <= '0;
            r_rc        <= '0;
            r_write     <= 1'b0;
            r_mode      <= 1'b0;
            r_cpu_reset <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_write <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (i_start) begin
                        r_addr      <= '0;
                        r_sum       <= '0;
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                        r_mode      <= 1'b1;
                        r_cpu_reset <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (w_transfer) begin
                        r_last_addr <= ADDR_WIDTH'(i_byte - DATA_WIDTH'(1));
                        if (w_count_ok) begin
                            r_state <= ST_DATA;
                        end else begin
                            r_mode  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_error <= 1'b1;
                            r_state <= ST_ERROR;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_transfer) begin
                        r_data  <= i_byte;
                        r_sum   <= r_sum + i_byte;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_write <= 1'b1;
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    // Address advances only after the hold cycle, so it never wraps on the last word.
                    if (r_addr == r_last_addr) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_addr  <= r_addr + ADDR_WIDTH'(1);
                        r_state <= ST_DATA;
                    end
                end
                ST_CHECK: begin
                    if (w_transfer) begin
                        r_mode <= 1'b0;
                        if (i_byte == r_sum) begin
                            r_rc    <= LP_RC_W'(RESET_CYCLES - 1);
                            r_state <= ST_RESET_CPU;
                        end else begin
                            r_busy  <= 1'b0;
                            r_error <= 1'b1;
                            r_state <= ST_ERROR;
                        end
                    end
                end
                ST_RESET_CPU: begin
                    if (r_rc == '0) begin
                        r_cpu_reset <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_rc <= r_rc - LP_RC_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_byte_ready      = w_ready;
    assign o_program_mode    = r_mode;
    assign o_program_address = r_addr;
    assign o_program_data    = r_data;
    assign o_program_write   = r_write;
    assign o_cpu_reset       = r_cpu_reset;
    assign o_busy            = r_busy;
    assign o_done            = r_done;
    assign o_error           = r_error;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized self-checking bench for program_loader
module tb_program_loader;

    typedef logic [7:0] byte_q_t[$];

    logic       clk;
    logic       rst;
    logic       i_debug;
    logic       i_start;
    logic [7:0] i_byte;
    logic       i_byte_valid;
    logic       o_byte_ready;
    logic       o_program_mode;
    logic [3:0] o_program_address;
    logic [7:0] o_program_data;
    logic       o_program_write;
    logic       o_cpu_reset;
    logic       o_busy;
    logic       o_done;
    logic       o_error;

    int errors = 0;
    int checks = 0;

    logic [3:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];

    program_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RESET_CYCLES(4)) dut (
        .i_clock          (clk),
        .i_reset          (rst),
        .i_debug          (i_debug),
        .i_start          (i_start),
        .i_byte           (i_byte),
        .i_byte_valid     (i_byte_valid),
        .o_byte_ready     (o_byte_ready),
        .o_program_mode   (o_program_mode),
        .o_program_address(o_program_address),
        .o_program_data   (o_program_data),
        .o_program_write  (o_program_write),
        .o_cpu_reset      (o_cpu_reset),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_error          (o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: address/data must be stable the cycle before, during and after each strobe.
    logic [3:0] prev_addr;
    logic [7:0] prev_data;
    logic       prev_write = 1'b0;
    logic       pending = 1'b0;
    logic [3:0] hold_addr;
    logic [7:0] hold_data;

    always @(negedge clk) begin
        if (!rst) begin
            if (pending) begin
                checks++;
                if (o_program_address !== hold_addr || o_program_data !== hold_data) begin
                    errors++;
                    $display("FAIL hold_stable: addr=%0h data=%0h required addr=%0h data=%0h",
                             o_program_address, o_program_data, hold_addr, hold_data);
                end
                pending = 1'b0;
            end
            if (o_program_write) begin
                checks++;
                if (prev_write || o_program_address !== prev_addr || o_program_data !== prev_data) begin
                    errors++;
                    $display("FAIL setup_stable: prev_write=%0b addr=%0h data=%0h required addr=%0h data=%0h single strobe",
                             prev_write, o_program_address, o_program_data, prev_addr, prev_data);
                end
                wr_addr_q.push_back(o_program_address);
                wr_data_q.push_back(o_program_data);
                hold_addr = o_program_address;
                hold_data = o_program_data;
                pending   = 1'b1;
            end
        end
        prev_addr  = o_program_address;
        prev_data  = o_program_data;
        prev_write = o_program_write;
    end

    function automatic byte_q_t make_frame(input int n, input bit corrupt);
        byte_q_t f;
        logic [7:0] s;
        s = 8'h00;
        f.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            f.push_back(8'($urandom));
            s = 8'((int'(s) + int'(f[i + 1])) % 256);
        end
        if (corrupt) s = s ^ 8'(1 << $urandom_range(0, 7));
        f.push_back(s);
        return f;
    endfunction

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({o_byte_ready, o_program_mode, o_program_address, o_program_data, o_program_write,
             o_cpu_reset, o_busy, o_done, o_error} !== 20'h0) begin
            errors++;
            $display("FAIL %s: rdy=%0b mode=%0b addr=%0h data=%0h wr=%0b cpurst=%0b busy=%0b done=%0b err=%0b required all 0",
                     name, o_byte_ready, o_program_mode, o_program_address, o_program_data,
                     o_program_write, o_cpu_reset, o_busy, o_done, o_error);
        end
    endtask

    // Drive one load and check it against the frame rules; abort_writes>0 stops feeding early.
    task automatic run_load(input string name, input byte_q_t frame, input bit gaps,
                            input bit start_noise, input int abort_writes);
        int  n;
        bit  legal;
        bit  ok;
        int  sum;
        int  ncons;
        int  idx;
        int  cyc;
        int  rc_cycles;
        bit  v;
        bit  accepted;
        int  acc_time[$];
        n     = int'(frame[0]);
        legal = (n >= 1) && (n <= 16);
        sum   = 0;
        if (legal) for (int i = 1; i <= n; i++) sum = (sum + int'(frame[i])) % 256;
        ok    = legal && (int'(frame[n + 1]) == sum);
        ncons = legal ? n + 2 : 1;

        wr_addr_q.delete();
        wr_data_q.delete();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;

        idx = 0;
        cyc = 0;
        while (idx < ncons && cyc < 3000) begin
            if (abort_writes > 0 && wr_addr_q.size() >= abort_writes) break;
            v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            i_byte_valid = v;
            i_byte       = v ? frame[idx] : 8'($urandom);
            i_start      = (start_noise && o_busy && $urandom_range(0, 3) == 0);
            accepted     = v && o_byte_ready;
            @(negedge clk);
            cyc++;
            if (accepted) begin
                if (idx >= 1 && idx <= n) acc_time.push_back(cyc);
                idx++;
            end
        end
        i_byte_valid = 1'b0;
        i_start      = 1'b0;
        if (abort_writes > 0) return;

        checks++;
        if (idx != ncons) begin
            errors++;
            $display("FAIL %s consumed: got %0d bytes required %0d", name, idx, ncons);
        end

        rc_cycles = 0;
        cyc = 0;
        while (!(o_done || o_error) && cyc < 200) begin
            if (o_cpu_reset && !o_program_mode) rc_cycles++;
            @(negedge clk);
            cyc++;
        end

        checks++;
        if (rc_cycles != (ok ? 4 : 0)) begin
            errors++;
            $display("FAIL %s cpu_reset_window: got %0d cycles required %0d", name, rc_cycles, ok ? 4 : 0);
        end

        checks++;
        if (o_done !== ok || o_error !== !ok || o_program_mode !== 1'b0 || o_cpu_reset !== !ok ||
            o_busy !== 1'b0 || o_byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s final: done=%0b err=%0b mode=%0b cpurst=%0b busy=%0b rdy=%0b required done=%0b err=%0b mode=0 cpurst=%0b busy=0 rdy=0",
                     name, o_done, o_error, o_program_mode, o_cpu_reset, o_busy, o_byte_ready, ok, !ok, !ok);
        end

        checks++;
        if (wr_addr_q.size() != (legal ? n : 0)) begin
            errors++;
            $display("FAIL %s write_count: got %0d required %0d", name, wr_addr_q.size(), legal ? n : 0);
        end else begin
            for (int i = 0; i < wr_addr_q.size(); i++) begin
                checks++;
                if (wr_addr_q[i] !== 4'(i) || wr_data_q[i] !== frame[i + 1]) begin
                    errors++;
                    $display("FAIL %s write[%0d]: got %0h@%0h required %0h@%0h",
                             name, i, wr_data_q[i], wr_addr_q[i], frame[i + 1], 4'(i));
                end
            end
        end

        if (!gaps && acc_time.size() > 1) begin
            for (int i = 1; i < acc_time.size(); i++) begin
                checks++;
                if (acc_time[i] - acc_time[i - 1] != 4) begin
                    errors++;
                    $display("FAIL %s throughput: byte %0d interval %0d required 4",
                             name, i + 1, acc_time[i] - acc_time[i - 1]);
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_state");
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("idle_after_reset");
    endtask

    task automatic test_nominal;
        byte_q_t f;
        f = '{8'h03, 8'h1E, 8'h2F, 8'hE0, 8'h2D};
        run_load("nominal", f, 1'b0, 1'b0, 0);
    endtask

    task automatic test_bad_checksum;
        byte_q_t f;
        f = '{8'h03, 8'h1E, 8'h2F, 8'hE0, 8'h2C};
        run_load("bad_checksum", f, 1'b0, 1'b0, 0);
    endtask

    task automatic test_illegal_count;
        byte_q_t f;
        f = '{8'h00};
        run_load("count_00", f, 1'b0, 1'b0, 0);
        f = '{8'h11};
        run_load("count_11", f, 1'b0, 1'b0, 0);
        f = '{8'h03, 8'h1E, 8'h2F, 8'hE0, 8'h2D};
        run_load("after_illegal", f, 1'b0, 1'b0, 0);
    endtask

    task automatic test_full_frame;
        byte_q_t f;
        f.push_back(8'h10);
        for (int i = 0; i < 16; i++) f.push_back(8'(i));
        f.push_back(8'h78);
        run_load("full_frame", f, 1'b0, 1'b0, 0);
    endtask

    task automatic test_random_gaps;
        for (int k = 0; k < 8; k++) begin
            run_load($sformatf("random_%0d", k), make_frame($urandom_range(1, 16), ($urandom_range(0, 3) == 0)),
                     1'b1, 1'b1, 0);
        end
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 3; k++) begin
            run_load($sformatf("b2b_%0d", k), make_frame($urandom_range(1, 16), 1'b0), 1'b0, 1'b0, 0);
        end
    endtask

    task automatic test_mid_load_reset;
        byte_q_t f;
        f = '{8'h03, 8'h1E, 8'h2F, 8'hE0, 8'h2D};
        run_load("abort", f, 1'b0, 1'b0, 2);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("async_reset");
        @(negedge clk);
        rst = 1'b0;
        run_load("after_reset", f, 1'b0, 1'b0, 0);
    endtask

    initial begin
        rst          = 1'b1;
        i_debug      = 1'b0;
        i_start      = 1'b0;
        i_byte       = 8'h00;
        i_byte_valid = 1'b0;
        test_reset();
        test_nominal();
        test_bad_checksum();
        test_illegal_count();
        test_full_frame();
        test_back_to_back();
        test_random_gaps();
        test_mid_load_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
